// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control FSM.
// States, opcodes, immediate formats, ALU ops and datapath mux codes.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_U     = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic [2:0] IMM_SHAMT = 3'd5;
  localparam logic [2:0] IMM_NONE  = 3'd7;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_EQ   = 4'd10;
  localparam logic [3:0] ALU_NE   = 4'd11;
  localparam logic [3:0] ALU_LT   = 4'd12;
  localparam logic [3:0] ALU_GE   = 4'd13;
  localparam logic [3:0] ALU_LTU  = 4'd14;
  localparam logic [3:0] ALU_GEU  = 4'd15;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_TARGET = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  function automatic logic opc_legal(input logic [6:0] op);
    return op inside {OPC_LOAD, OPC_OPIMM, OPC_AUIPC,
                      OPC_STORE, OPC_OP, OPC_LUI,
                      OPC_BRANCH, OPC_JALR, OPC_JAL,
                      OPC_FENCE, OPC_SYSTEM};
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation select from opcode, funct3 and instr[30].
// Arithmetic for OP/OP-IMM, compares for BRANCH, ADD for everything else.
module alu_op_decoder (
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_bit30,
  output logic [3:0] o_alu_op
);
  import riscv_ctrl_pkg::*;

  logic w_is_op;
  logic w_is_arith;
  logic w_is_br;

  assign w_is_op    = (i_opcode == OPC_OP);
  assign w_is_arith = w_is_op | (i_opcode == OPC_OPIMM);
  assign w_is_br    = (i_opcode == OPC_BRANCH);

  always_comb begin
    o_alu_op = ALU_ADD;
    unique case (1'b1)
      w_is_arith: begin
        case (i_funct3)
          3'b000:  o_alu_op = (w_is_op & i_bit30) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_op = ALU_SLL;
          3'b010:  o_alu_op = ALU_SLT;
          3'b011:  o_alu_op = ALU_SLTU;
          3'b100:  o_alu_op = ALU_XOR;
          3'b101:  o_alu_op = i_bit30 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_op = ALU_OR;
          default: o_alu_op = ALU_AND;
        endcase
      end
      w_is_br: begin
        case (i_funct3)
          3'b001:  o_alu_op = ALU_NE;
          3'b100:  o_alu_op = ALU_LT;
          3'b101:  o_alu_op = ALU_GE;
          3'b110:  o_alu_op = ALU_LTU;
          3'b111:  o_alu_op = ALU_GEU;
          default: o_alu_op = ALU_EQ;
        endcase
      end
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT over a
// shared datapath, owning the single memory port handshake.
module multicycle_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  imm_type,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);
  import riscv_ctrl_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;
  logic             r_bus_err;

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic       w_load, w_store, w_op, w_opimm;
  logic       w_lui, w_auipc, w_br, w_jal;
  logic       w_jalr, w_fence, w_sys, w_legal;
  logic       w_limit;
  logic [3:0] w_alu_op;
  logic [2:0] w_imm;
  logic       w_unused_bits;

  assign w_opc   = instr[6:0];
  assign w_f3    = instr[14:12];
  assign w_load  = (w_opc == OPC_LOAD);
  assign w_store = (w_opc == OPC_STORE);
  assign w_op    = (w_opc == OPC_OP);
  assign w_opimm = (w_opc == OPC_OPIMM);
  assign w_lui   = (w_opc == OPC_LUI);
  assign w_auipc = (w_opc == OPC_AUIPC);
  assign w_br    = (w_opc == OPC_BRANCH);
  assign w_jal   = (w_opc == OPC_JAL);
  assign w_jalr  = (w_opc == OPC_JALR);
  assign w_fence = (w_opc == OPC_FENCE);
  assign w_sys   = (w_opc == OPC_SYSTEM);
  assign w_legal = opc_legal(w_opc);
  assign w_limit = (r_cnt == CNT_W'(MEM_WAIT_MAX - 1));

  assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_op_decoder u_alu_dec (
    .i_opcode (w_opc),
    .i_funct3 (w_f3),
    .i_bit30  (instr[30]),
    .o_alu_op (w_alu_op)
  );

  always_comb begin
    w_imm = IMM_NONE;
    unique case (1'b1)
      w_load | w_jalr: w_imm = IMM_I;
      w_opimm: w_imm = (w_f3 == 3'b001 || w_f3 == 3'b101) ?
                       IMM_SHAMT : IMM_I;
      w_store:         w_imm = IMM_S;
      w_br:            w_imm = IMM_B;
      w_lui | w_auipc: w_imm = IMM_U;
      w_jal:           w_imm = IMM_J;
      default:         w_imm = IMM_NONE;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    imm_type     = IMM_NONE;
    if (r_state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      imm_type  = w_imm;
      alu_op    = w_alu_op;
      alu_src_a = w_auipc | w_jal;
      alu_src_b = ~(w_op | w_br);
    end
    unique case (r_state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_DECODE: pc_write = w_fence;
      S_EXEC: begin
        pc_write = w_br;
        pc_src   = (w_br & branch_taken) ? PC_TARGET : PC_PLUS4;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = w_store;
        pc_write     = w_store & mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_src    = w_jal ? PC_TARGET :
                    w_jalr ? PC_JALR : PC_PLUS4;
        wb_sel    = w_load ? WB_MEM :
                    (w_jal | w_jalr) ? WB_PC4 :
                    w_lui ? WB_IMM : WB_ALU;
      end
      default: ;
    endcase
    // Reset masks every strobe, including a coincident mem_ready.
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = '0;
      reg_write    = 1'b0;
      wb_sel       = '0;
      alu_src_a    = 1'b0;
      alu_src_b    = 1'b0;
      alu_op       = '0;
      imm_type     = '0;
    end
  end

  assign halted  = ~rst & (r_state == S_HALT);
  assign illegal = ~rst & r_illegal;
  assign bus_err = ~rst & r_bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
            r_cnt   <= '0;
          end else if (w_limit) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          if (!w_legal) begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end else if (w_sys) begin
            r_state <= S_HALT;
          end else if (w_fence) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt <= '0;
          if (w_load | w_store) r_state <= S_MEM;
          else if (w_br)        r_state <= S_FETCH;
          else                  r_state <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            r_cnt   <= '0;
            r_state <= w_load ? S_WB : S_FETCH;
          end else if (w_limit) begin
            r_state   <= S_HALT;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          r_state <= S_FETCH;
          r_cnt   <= '0;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed cases plus random instruction
// streams checked against a phase-level model of the control sequence.
module tb_multicycle_ctrl_fsm;
  import riscv_ctrl_pkg::*;

  localparam int MAXW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src, wb_sel;
  logic        reg_write, alu_src_a, alu_src_b;
  logic [3:0]  alu_op;
  logic [2:0]  imm_type;
  logic        halted, illegal, bus_err;

  multicycle_ctrl_fsm #(.MEM_WAIT_MAX(MAXW), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_type(imm_type),
    .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef enum int {
    C_LOAD, C_STORE, C_OP, C_OPIMM, C_LUI, C_AUIPC,
    C_BR, C_JAL, C_JALR, C_FENCE, C_SYS, C_ILL
  } cls_t;
  typedef enum int {P_F, P_D, P_E, P_M, P_W, P_H} ph_t;

  int n_err = 0;
  int n_chk = 0;
  int n_pcw = 0;
  int n_rw  = 0;
  int n_req = 0;

  logic [12:0] obs;
  assign obs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
                reg_write, pc_src, wb_sel, halted, illegal, bus_err};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'h03:   return C_LOAD;
      7'h23:   return C_STORE;
      7'h33:   return C_OP;
      7'h13:   return C_OPIMM;
      7'h37:   return C_LUI;
      7'h17:   return C_AUIPC;
      7'h63:   return C_BR;
      7'h6F:   return C_JAL;
      7'h67:   return C_JALR;
      7'h0F:   return C_FENCE;
      7'h73:   return C_SYS;
      default: return C_ILL;
    endcase
  endfunction

  // Expected strobe vector for one cycle of a given phase.
  function automatic logic [12:0] exp_obs(input ph_t p, input cls_t c,
      input logic rdy, input logic tk, input logic ill, input logic be);
    logic req, we, as, irw, pcw, rw, h;
    logic [1:0] ps, ws;
    {req, we, as, irw, pcw, rw, h} = '0;
    ps = 2'd0;
    ws = 2'd0;
    case (p)
      P_F: begin req = 1'b1; irw = rdy; end
      P_D: pcw = (c == C_FENCE);
      P_E: if (c == C_BR) begin pcw = 1'b1; ps = tk ? 2'd1 : 2'd0; end
      P_M: begin
        req = 1'b1; as = 1'b1;
        we  = (c == C_STORE);
        pcw = (c == C_STORE) && rdy;
      end
      P_W: begin
        rw = 1'b1; pcw = 1'b1;
        ps = (c == C_JAL) ? 2'd1 : (c == C_JALR) ? 2'd2 : 2'd0;
        ws = (c == C_LOAD) ? 2'd1 :
             (c == C_JAL || c == C_JALR) ? 2'd2 :
             (c == C_LUI) ? 2'd3 : 2'd0;
      end
      default: h = 1'b1;
    endcase
    return {req, we, as, irw, pcw, rw, ps, ws, h,
            (p == P_H) ? ill : 1'b0, (p == P_H) ? be : 1'b0};
  endfunction

  function automatic int exp_imm(input cls_t c, input logic [2:0] f3);
    case (c)
      C_LOAD, C_JALR: return int'(IMM_I);
      C_OPIMM: return (f3 == 3'd1 || f3 == 3'd5) ?
                      int'(IMM_SHAMT) : int'(IMM_I);
      C_STORE: return int'(IMM_S);
      C_BR:    return int'(IMM_B);
      C_LUI, C_AUIPC: return int'(IMM_U);
      C_JAL:   return int'(IMM_J);
      C_OP:    return int'(IMM_NONE);
      default: return -1;
    endcase
  endfunction

  function automatic int exp_alu(input cls_t c, input logic [2:0] f3,
                                 input logic b30);
    logic [3:0] ar [8];
    logic [3:0] br [8];
    ar = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
           ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    br = '{ALU_EQ, ALU_NE, ALU_EQ, ALU_EQ,
           ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    case (c)
      C_LOAD, C_STORE, C_AUIPC, C_JALR: return int'(ALU_ADD);
      C_OP, C_OPIMM: begin
        if (f3 == 3'd0 && c == C_OP && b30) return int'(ALU_SUB);
        if (f3 == 3'd5 && b30) return int'(ALU_SRA);
        return int'(ar[f3]);
      end
      C_BR:    return int'(br[f3]);
      default: return -1;
    endcase
  endfunction

  function automatic int exp_src(input cls_t c);
    case (c)
      C_OP, C_BR: return 0;
      C_OPIMM, C_LOAD, C_STORE: return 1;
      C_AUIPC: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic step(input logic [31:0] ins, input logic rdy,
                      input logic tk, input logic [12:0] e,
                      input string tag);
    @(negedge clk);
    rst = 1'b0;
    instr = ins;
    mem_ready = rdy;
    branch_taken = tk;
    #1;
    check(tag, 32'(obs), 32'(e));
    if (pc_write)  n_pcw++;
    if (reg_write) n_rw++;
    if (mem_req)   n_req++;
  endtask

  task automatic do_reset(input logic rdy, input string tag);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = rdy;
    branch_taken = 1'($urandom_range(0, 1));
    #1;
    check(tag, 32'({obs, imm_type, alu_op, alu_src_a, alu_src_b}), 0);
  endtask

  task automatic run_instr(input string nm, input logic [31:0] ins,
                           input int wf, input int wm, input int tkm);
    cls_t c;
    ph_t pq[$];
    logic rq[$];
    logic hi, hb, halt, tk, wbc;
    int pcw0, rw0, rq0, exp_req, e_imm, e_alu, e_src;
    c = classify(ins[6:0]);
    hi = 1'b0; hb = 1'b0; halt = 1'b0;
    for (int i = 0; i < wf && i < MAXW; i++) begin
      pq.push_back(P_F); rq.push_back(1'b0);
    end
    exp_req = (wf >= MAXW) ? MAXW : wf + 1;
    if (wf >= MAXW) begin
      halt = 1'b1; hb = 1'b1;
    end else begin
      pq.push_back(P_F); rq.push_back(1'b1);
      pq.push_back(P_D); rq.push_back(1'($urandom_range(0, 1)));
      if (c == C_ILL) begin
        halt = 1'b1; hi = 1'b1;
      end else if (c == C_SYS) begin
        halt = 1'b1;
      end else if (c != C_FENCE) begin
        pq.push_back(P_E); rq.push_back(1'($urandom_range(0, 1)));
        if (c == C_LOAD || c == C_STORE) begin
          for (int i = 0; i < wm && i < MAXW; i++) begin
            pq.push_back(P_M); rq.push_back(1'b0);
          end
          exp_req += (wm >= MAXW) ? MAXW : wm + 1;
          if (wm >= MAXW) begin
            halt = 1'b1; hb = 1'b1;
          end else begin
            pq.push_back(P_M); rq.push_back(1'b1);
            if (c == C_LOAD) begin
              pq.push_back(P_W); rq.push_back(1'($urandom_range(0, 1)));
            end
          end
        end else if (c != C_BR) begin
          pq.push_back(P_W); rq.push_back(1'($urandom_range(0, 1)));
        end
      end
    end
    pcw0 = n_pcw; rw0 = n_rw; rq0 = n_req;
    foreach (pq[i]) begin
      tk = (tkm < 0) ? 1'($urandom_range(0, 1)) : 1'(tkm);
      step(ins, rq[i], tk, exp_obs(pq[i], c, rq[i], tk, 1'b0, 1'b0),
           $sformatf("%s.cyc%0d", nm, i));
      if (pq[i] == P_D) begin
        e_imm = exp_imm(c, ins[14:12]);
        if (e_imm >= 0)
          check($sformatf("%s.imm", nm), 32'(imm_type), 32'(e_imm));
      end
      if (pq[i] == P_E) begin
        e_alu = exp_alu(c, ins[14:12], ins[30]);
        e_src = exp_src(c);
        if (e_alu >= 0)
          check($sformatf("%s.alu", nm), 32'(alu_op), 32'(e_alu));
        if (e_src >= 0)
          check($sformatf("%s.src", nm),
                32'({alu_src_a, alu_src_b}), 32'(e_src));
      end
    end
    if (halt) begin
      for (int k = 0; k < 3; k++)
        step(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             exp_obs(P_H, c, 1'b0, 1'b0, hi, hb),
             $sformatf("%s.halt%0d", nm, k));
    end
    wbc = !halt && (c inside {C_LOAD, C_OP, C_OPIMM, C_LUI,
                              C_AUIPC, C_JAL, C_JALR});
    check($sformatf("%s.npcw", nm), 32'(n_pcw - pcw0), halt ? 0 : 1);
    check($sformatf("%s.nrw", nm), 32'(n_rw - rw0), 32'(wbc));
    check($sformatf("%s.nreq", nm), 32'(n_req - rq0), 32'(exp_req));
    if (halt) do_reset(1'($urandom_range(0, 1)), {nm, ".rst"});
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return MAXW;
    if (r == 1) return MAXW - 1;
    return $urandom_range(0, 3);
  endfunction

  initial begin
    logic [6:0]  ops [11];
    logic [2:0]  bf [6];
    logic [31:0] ins;
    logic [6:0]  op;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37,
            7'h63, 7'h67, 7'h6F, 7'h0F, 7'h73};
    bf  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    do_reset(1'b0, "rst0");
    do_reset(1'b1, "rst1");

    run_instr("addi", 32'h00500093, 0, 0, -1);
    run_instr("lw", 32'h0000A103, 0, 3, -1);
    run_instr("beq_t", 32'h00000063, 0, 0, 1);
    run_instr("beq_n", 32'h00000063, 0, 0, 0);
    run_instr("sw", 32'h0020A023, 1, 2, -1);
    run_instr("sub", 32'h402081B3, 0, 0, -1);
    run_instr("srai", 32'h4030D093, 2, 0, -1);
    run_instr("lui", 32'h123450B7, 0, 0, -1);
    run_instr("jal", 32'h008000EF, 0, 0, -1);
    run_instr("jalr", 32'h000080E7, 0, 0, -1);
    run_instr("fence", 32'h0000000F, 0, 0, -1);
    run_instr("ill", 32'h0000007F, 0, 0, -1);
    run_instr("ecall", 32'h00000073, 0, 0, -1);
    run_instr("to_f", 32'h00500093, MAXW, 0, -1);
    run_instr("lim_f", 32'h00500093, MAXW - 1, 0, -1);
    run_instr("to_m", 32'h0000A103, 0, MAXW, -1);
    run_instr("lim_m", 32'h0020A023, 0, MAXW - 1, -1);

    // Reset lands in MEM together with mem_ready.
    ins = 32'h0000A103;
    step(ins, 1'b1, 1'b0, exp_obs(P_F, C_LOAD, 1'b1, 1'b0, 1'b0, 1'b0),
         "rm.f");
    step(ins, 1'b0, 1'b0, exp_obs(P_D, C_LOAD, 1'b0, 1'b0, 1'b0, 1'b0),
         "rm.d");
    step(ins, 1'b0, 1'b0, exp_obs(P_E, C_LOAD, 1'b0, 1'b0, 1'b0, 1'b0),
         "rm.e");
    do_reset(1'b1, "rm.rst");
    run_instr("after_rm", 32'h00500093, 0, 0, -1);

    for (int n = 0; n < 150; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 99) < 5) begin
        do op = 7'($urandom); while (classify(op) != C_ILL);
        ins[6:0] = op;
      end else begin
        ins[6:0] = ops[$urandom_range(0, 10)];
        if (ins[6:0] == 7'h63) ins[14:12] = bf[$urandom_range(0, 5)];
      end
      run_instr($sformatf("rnd%0d", n), ins, pick_wait(), pick_wait(), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
